// File: rtl/l1_cache_responder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : l1_cache_responder_if
// Description : Datapath request bus and physical-memory line bus of the L1.
// Revision    : 1.0 - initial release
// ============================================================================
interface l1_cache_responder_if;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    // Cache side: answers the datapath, drives the memory port.
    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    // Environment side: datapath requester plus memory arbiter.
    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/l1_cache_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : l1_cache_responder
// Description : Direct-mapped write-back L1 cache, 0-cycle hit, 256-bit lines.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_cache_responder #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
) (
    input  wire logic            clk,
    input  wire logic            rst,
    l1_cache_responder_if.slave  bus
);

    localparam int c_TAG_W  = 32 - S_INDEX - S_OFFSET;
    localparam int c_SETS   = 1 << S_INDEX;
    localparam int c_LINE_W = 8 << S_OFFSET;
    localparam int c_WSEL_W = S_OFFSET - 2;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WRITEBACK = 2'd1;
    localparam logic [1:0] c_ALLOCATE  = 2'd2;

    logic [1:0]          r_state;
    logic [c_SETS-1:0]   r_valid;
    logic [c_SETS-1:0]   r_dirty;
    logic [c_TAG_W-1:0]  r_tag  [c_SETS];
    logic [c_LINE_W-1:0] r_data [c_SETS];

    logic [S_INDEX-1:0]  w_idx;
    logic [c_TAG_W-1:0]  w_tag;
    logic [c_WSEL_W-1:0] w_wsel;
    logic                w_req;
    logic                w_hit;
    logic                w_hit_resp;
    logic                w_fill_done;
    logic [c_LINE_W-1:0] w_line;
    logic [31:0]         w_word;
    logic [c_LINE_W-1:0] w_merged_line;

    assign w_idx  = bus.mem_address[S_OFFSET +: S_INDEX];
    assign w_tag  = bus.mem_address[31 -: c_TAG_W];
    assign w_wsel = bus.mem_address[2 +: c_WSEL_W];
    assign w_req  = bus.mem_read | bus.mem_write;
    assign w_hit  = r_valid[w_idx] & (r_tag[w_idx] == w_tag);

    assign w_line = r_data[w_idx];
    assign w_word = w_line[{w_wsel, 5'd0} +: 32];

    // Hits answer combinationally; nothing is ever acknowledged outside IDLE.
    assign w_hit_resp  = (r_state == c_IDLE) & w_req & w_hit;
    assign w_fill_done = (r_state == c_ALLOCATE) & bus.pmem_resp;

    always_comb begin
        w_merged_line = w_line;
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_byte_enable[b]) begin
                w_merged_line[{w_wsel, b[1:0], 3'd0} +: 8] = bus.mem_wdata[b*8 +: 8];
            end
        end
    end

    assign bus.mem_resp   = w_hit_resp;
    assign bus.mem_rdata  = w_hit_resp ? w_word : 32'd0;
    assign bus.pmem_write = (r_state == c_WRITEBACK);
    assign bus.pmem_read  = (r_state == c_ALLOCATE);
    assign bus.pmem_wdata = (r_state == c_WRITEBACK) ? w_line : '0;

    always_comb begin
        bus.pmem_address = 32'd0;
        case (r_state)
            c_WRITEBACK: bus.pmem_address = {r_tag[w_idx], w_idx, {S_OFFSET{1'b0}}};
            c_ALLOCATE:  bus.pmem_address = {w_tag, w_idx, {S_OFFSET{1'b0}}};
            default:     bus.pmem_address = 32'd0;
        endcase
    end

    // Control state: reset asynchronously so strobes drop without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (bus.mem_write) begin
                                r_dirty[w_idx] <= 1'b1;
                            end
                        end else if (r_dirty[w_idx]) begin
                            r_state <= c_WRITEBACK;
                        end else begin
                            r_state <= c_ALLOCATE;
                        end
                    end
                end
                c_WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= c_ALLOCATE;
                    end
                end
                c_ALLOCATE: begin
                    if (bus.pmem_resp) begin
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Tags and line data carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_data[w_idx] <= bus.pmem_rdata;
            r_tag[w_idx]  <= w_tag;
        end else if (w_hit_resp && bus.mem_write) begin
            r_data[w_idx] <= w_merged_line;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l1_cache_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_l1_cache_responder
// Description : Scoreboard bench for l1_cache_responder with a latency pmem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_cache_responder;

    localparam int c_PMEM_LAT = 3;

    logic clk;
    logic rst;

    l1_cache_responder_if bus ();

    l1_cache_responder #(.S_INDEX(3), .S_OFFSET(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [255:0] data;
    } pmem_txn_t;

    pmem_txn_t    pmem_log [$];
    logic [255:0] pmem_mem [logic [31:0]];
    logic [31:0]  ref_word [logic [31:0]];
    logic [31:0]  sb_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;
    bit           both_seen = 1'b0;

    function automatic logic [255:0] line_init(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = {16'hC0DE ^ la[15:0], la[15:0] + 16'(i * 4)};
        end
        if (la == 32'h40) l[63:32] = 32'hDEAD_BEEF;
        return l;
    endfunction

    function automatic logic [255:0] pmem_line(input logic [31:0] la);
        if (pmem_mem.exists(la)) return pmem_mem[la];
        return line_init(la);
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        logic [31:0]  aw;
        logic [255:0] l;
        aw = {a[31:2], 2'b00};
        if (ref_word.exists(aw)) return ref_word[aw];
        l = line_init({a[31:5], 5'd0});
        return l[int'(a[4:2]) * 32 +: 32];
    endfunction

    function automatic void ref_put(input logic [31:0] a, input logic [3:0] be,
                                    input logic [31:0] wd);
        logic [31:0] w;
        w = ref_get(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        ref_word[{a[31:2], 2'b00}] = w;
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = ref_get(la + 32'(i * 4));
        return l;
    endfunction

    // Physical memory: answers each held strobe after c_PMEM_LAT falling edges.
    initial begin
        int cnt;
        cnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (!rst && (bus.pmem_read || bus.pmem_write)) begin
                cnt++;
                if (cnt >= c_PMEM_LAT) begin
                    cnt = 0;
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_write) begin
                        pmem_mem[bus.pmem_address] = bus.pmem_wdata;
                        pmem_log.push_back('{1'b1, bus.pmem_address, bus.pmem_wdata});
                    end else begin
                        bus.pmem_rdata = pmem_line(bus.pmem_address);
                        pmem_log.push_back('{1'b0, bus.pmem_address, bus.pmem_rdata});
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.pmem_read && bus.pmem_write) both_seen = 1'b1;
    end

    // Drives one request from just after a rising edge; returns response info.
    task automatic run_access(input logic [31:0] addr, input logic rd, input logic wr,
                              input logic [3:0] be, input logic [31:0] wd,
                              output bit got, output int lat, output logic [31:0] rdata);
        bus.mem_address     = addr;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        got   = 1'b0;
        lat   = -1;
        rdata = '0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (bus.mem_resp) begin
                got   = 1'b1;
                lat   = c;
                rdata = bus.mem_rdata;
            end
        end
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++; if (bus.mem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_mem_resp: got %0b required 0", bus.mem_resp); end
        n_checks++; if (bus.mem_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_rdata: got %h required 0", bus.mem_rdata); end
        n_checks++; if (bus.pmem_read !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_read: got %0b required 0", bus.pmem_read); end
        n_checks++; if (bus.pmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_write: got %0b required 0", bus.pmem_write); end
        n_checks++; if (bus.pmem_address !== 32'd0) begin n_fail++; $display("FAIL reset_pmem_address: got %h required 0", bus.pmem_address); end
    endtask

    task automatic test_cold_miss;
        bit got; int lat; logic [31:0] rd, exp;
        pmem_log.delete();
        sb_q.push_back(ref_get(32'h44));
        run_access(32'h44, 1'b1, 1'b0, 4'h0, 32'h0, got, lat, rd);
        exp = sb_q.pop_front();
        n_checks++; if (!got) begin n_fail++; $display("FAIL cold_miss_resp: got no response required mem_resp"); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL cold_miss_latency: got %0d required 4", lat); end
        n_checks++; if (rd !== exp || rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cold_miss_rdata: got %h required %h", rd, exp); end
        n_checks++;
        if (pmem_log.size() !== 1) begin
            n_fail++; $display("FAIL cold_miss_pmem_count: got %0d required 1", pmem_log.size());
        end else if (pmem_log[0].is_write || pmem_log[0].addr !== 32'h40) begin
            n_fail++; $display("FAIL cold_miss_pmem_txn: got write=%0b addr=%h required read addr 00000040",
                               pmem_log[0].is_write, pmem_log[0].addr);
        end
    endtask

    task automatic test_back_to_back;
        bit got; int lat; logic [31:0] rd, exp;
        logic [31:0] addrs [2];
        addrs[0] = 32'h44;
        addrs[1] = 32'h40;
        pmem_log.delete();
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(ref_get(addrs[i]));
            run_access(addrs[i], 1'b1, 1'b0, 4'h0, 32'h0, got, lat, rd);
            exp = sb_q.pop_front();
            n_checks++; if (!got || lat !== 0) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d required 0", i, lat); end
            n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h required %h", i, rd, exp); end
        end
        n_checks++; if (pmem_log.size() !== 0) begin n_fail++; $display("FAIL b2b_pmem_idle: got %0d transfers required 0", pmem_log.size()); end
    endtask

    task automatic test_byte_write;
        bit got; int lat; logic [31:0] rd, exp;
        pmem_log.delete();
        ref_put(32'h44, 4'b0101, 32'h1122_3344);
        run_access(32'h44, 1'b0, 1'b1, 4'b0101, 32'h1122_3344, got, lat, rd);
        n_checks++; if (!got || lat !== 0) begin n_fail++; $display("FAIL bytewrite_latency: got %0d required 0", lat); end
        sb_q.push_back(ref_get(32'h44));
        run_access(32'h44, 1'b1, 1'b0, 4'h0, 32'h0, got, lat, rd);
        exp = sb_q.pop_front();
        n_checks++; if (rd !== exp || rd !== 32'hDE22_BE44) begin n_fail++; $display("FAIL bytewrite_rdata: got %h required %h", rd, exp); end
        n_checks++; if (pmem_log.size() !== 0) begin n_fail++; $display("FAIL bytewrite_pmem_idle: got %0d transfers required 0", pmem_log.size()); end
    endtask

    task automatic test_rw_simul;
        bit got; int lat; logic [31:0] rd, exp;
        ref_put(32'h48, 4'hF, 32'hA5A5_A5A5);
        run_access(32'h48, 1'b1, 1'b1, 4'hF, 32'hA5A5_A5A5, got, lat, rd);
        n_checks++; if (!got || lat !== 0) begin n_fail++; $display("FAIL rw_latency: got %0d required 0", lat); end
        sb_q.push_back(ref_get(32'h48));
        run_access(32'h48, 1'b1, 1'b0, 4'h0, 32'h0, got, lat, rd);
        exp = sb_q.pop_front();
        n_checks++; if (rd !== exp || rd !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL rw_rdata: got %h required %h", rd, exp); end
    endtask

    task automatic test_dirty_evict;
        bit got; int lat; logic [31:0] rd, exp;
        logic [255:0] victim;
        victim = ref_line(32'h40);
        pmem_log.delete();
        sb_q.push_back(ref_get(32'h140));
        run_access(32'h140, 1'b1, 1'b0, 4'h0, 32'h0, got, lat, rd);
        exp = sb_q.pop_front();
        n_checks++; if (!got || lat !== 7) begin n_fail++; $display("FAIL evict_latency: got %0d required 7", lat); end
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL evict_rdata: got %h required %h", rd, exp); end
        n_checks++;
        if (pmem_log.size() !== 2) begin
            n_fail++; $display("FAIL evict_pmem_count: got %0d required 2", pmem_log.size());
        end else begin
            if (!pmem_log[0].is_write || pmem_log[0].addr !== 32'h40 || pmem_log[0].data !== victim) begin
                n_fail++; $display("FAIL evict_writeback: got write=%0b addr=%h data=%h required write addr 00000040 data=%h",
                                   pmem_log[0].is_write, pmem_log[0].addr, pmem_log[0].data, victim);
            end
            n_checks++;
            if (pmem_log[1].is_write || pmem_log[1].addr !== 32'h140) begin
                n_fail++; $display("FAIL evict_fill: got write=%0b addr=%h required read addr 00000140",
                                   pmem_log[1].is_write, pmem_log[1].addr);
            end
        end
        // The written-back line must come home intact through a clean miss.
        pmem_log.delete();
        sb_q.push_back(ref_get(32'h44));
        run_access(32'h44, 1'b1, 1'b0, 4'h0, 32'h0, got, lat, rd);
        exp = sb_q.pop_front();
        n_checks++; if (!got || lat !== 4) begin n_fail++; $display("FAIL reload_latency: got %0d required 4", lat); end
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL reload_rdata: got %h required %h", rd, exp); end
        n_checks++; if (pmem_log.size() !== 1) begin n_fail++; $display("FAIL reload_pmem_count: got %0d required 1", pmem_log.size()); end
    endtask

    task automatic test_dropped_request;
        bit got; int lat; logic [31:0] rd, exp;
        bit bad_resp;
        int settle;
        pmem_log.delete();
        bad_resp = 1'b0;
        settle   = 0;
        bus.mem_address = 32'h80;
        bus.mem_read    = 1'b1;
        bus.mem_write   = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.mem_resp) bad_resp = 1'b1;
        end
        bus.mem_read = 1'b0;
        for (int c = 0; c < 30 && settle < 3; c++) begin
            @(negedge clk);
            if (bus.mem_resp) bad_resp = 1'b1;
            if (pmem_log.size() != 0) settle++;
        end
        n_checks++; if (bad_resp !== 1'b0) begin n_fail++; $display("FAIL dropped_no_resp: got resp=%0b required 0", bad_resp); end
        n_checks++;
        if (pmem_log.size() !== 1) begin
            n_fail++; $display("FAIL dropped_fill_count: got %0d required 1", pmem_log.size());
        end else if (pmem_log[0].is_write || pmem_log[0].addr !== 32'h80) begin
            n_fail++; $display("FAIL dropped_fill_txn: got addr=%h required read addr 00000080", pmem_log[0].addr);
        end
        @(posedge clk);
        #1;
        sb_q.push_back(ref_get(32'h84));
        run_access(32'h84, 1'b1, 1'b0, 4'h0, 32'h0, got, lat, rd);
        exp = sb_q.pop_front();
        n_checks++; if (!got || lat !== 0) begin n_fail++; $display("FAIL dropped_then_hit_latency: got %0d required 0", lat); end
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL dropped_then_hit_rdata: got %h required %h", rd, exp); end
    endtask

    task automatic test_reset_mid_fill;
        bit got; int lat; logic [31:0] rd, exp;
        bit seen;
        seen = 1'b0;
        bus.mem_address = 32'h1A0;
        bus.mem_read    = 1'b1;
        bus.mem_write   = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.pmem_read) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL midfill_allocate: got pmem_read=0 required 1"); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.pmem_read !== 1'b0) begin n_fail++; $display("FAIL midfill_pmem_read: got %0b required 0", bus.pmem_read); end
        n_checks++; if (bus.mem_resp !== 1'b0) begin n_fail++; $display("FAIL midfill_mem_resp: got %0b required 0", bus.mem_resp); end
        bus.mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        pmem_log.delete();
        sb_q.push_back(ref_get(32'h1A0));
        run_access(32'h1A0, 1'b1, 1'b0, 4'h0, 32'h0, got, lat, rd);
        exp = sb_q.pop_front();
        n_checks++; if (!got || lat !== 4) begin n_fail++; $display("FAIL midfill_reread_latency: got %0d required 4", lat); end
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL midfill_reread_rdata: got %h required %h", rd, exp); end
        sb_q.push_back(ref_get(32'h44));
        run_access(32'h44, 1'b1, 1'b0, 4'h0, 32'h0, got, lat, rd);
        exp = sb_q.pop_front();
        n_checks++; if (!got || lat !== 4) begin n_fail++; $display("FAIL midfill_invalidated_latency: got %0d required 4", lat); end
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL midfill_invalidated_rdata: got %h required %h", rd, exp); end
    endtask

    initial begin
        rst                 = 1'b1;
        bus.mem_address     = 32'd0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 4'h0;
        bus.mem_wdata       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_cold_miss();
        test_back_to_back();
        test_byte_write();
        test_rw_simul();
        test_dirty_evict();
        test_dropped_request();
        test_reset_mid_fill();
        n_checks++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL pmem_strobe_exclusive: got both high required never"); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/l1_cache_responder.md
Name: l1_cache_responder

Overview:
- Direct-mapped, write-back L1 cache that answers the pipeline controller's icache/dcache read and write strobes with a single-cycle mem_resp on hit.
- On a miss it stalls the requester and moves 256-bit lines over the physical-memory port.
- One instance serves the instruction side and one serves the data side. Both sit between the datapath and the memory arbiter.

Parameters:
- S_INDEX, 3, log2 of set count (8 sets); index = address[5 +: S_INDEX].
- S_OFFSET, 5, log2 of line bytes (32 B line, 8 words); fixed by the 256-bit pmem bus.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_address  in  32  byte address from datapath; bits [1:0] ignored
- mem_read  in  1  read request, held until mem_resp
- mem_write  in  1  write request, held until mem_resp
- mem_byte_enable  in  4  byte lanes for a write
- mem_wdata  in  32  write data
- mem_rdata  out  32  read data, valid when mem_resp
- mem_resp  out  1  request complete, asserted for one cycle per access
- pmem_address  out  32  line address, [4:0]=0
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line write-back request, held until pmem_resp
- pmem_wdata  out  256  victim line
- pmem_rdata  in  256  fill line
- pmem_resp  in  1  pmem transfer done

Behaviour:
- Storage: per set {valid, dirty, tag[31-S_INDEX-S_OFFSET:0], data[255:0]}, held in flops. The tag is address[31:S_INDEX+S_OFFSET]. Word select is address[4:2].
- Reset (async, any state): all valid and dirty bits cleared, state=IDLE. mem_resp, pmem_read and pmem_write go to 0, pmem_address to 0, mem_rdata to 0. Tags and data need not reset.
- Request: req = mem_read | mem_write. If both are high, the access is treated as a write.
- hit = valid[idx] & (tag[idx] == addr tag).
- States:
  - IDLE
    - req & hit: mem_resp=1 combinationally in the same cycle (0-cycle hit latency).
      - Read: mem_rdata = word[addr[4:2]].
      - Write: at the clock edge, bytes where mem_byte_enable[i]=1 replace the matching byte of that word; dirty[idx] is set. Other bytes and words are unchanged.
      - Stay IDLE.
    - req & !hit & dirty[idx] -> WRITEBACK.
    - req & !hit & !dirty[idx] -> ALLOCATE.
    - !req: mem_resp=0, stay IDLE.
  - WRITEBACK
    - pmem_write=1.
    - pmem_address = {stored tag, idx, 5'b0}.
    - pmem_wdata = data[idx].
    - On pmem_resp: dirty[idx]=0, -> ALLOCATE.
  - ALLOCATE
    - pmem_read=1.
    - pmem_address = {addr tag, idx, 5'b0}.
    - On pmem_resp: data[idx]=pmem_rdata, tag written, valid=1, dirty=0, -> IDLE.
    - The next cycle is then a hit and answers normally, so a miss costs (write-back) + fill + 1 cycles.
- mem_resp is never asserted outside IDLE.
- pmem_read and pmem_write are never both high.
- A request that drops during WRITEBACK or ALLOCATE does not abort the transfer. The line completes, and no mem_resp is issued for the dropped request.
- The address and write data must stay stable while the request is held. The cache does not latch them.
- pmem_resp in IDLE is ignored.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE: the transfer is abandoned, the strobes drop immediately (async), and all lines are invalid afterwards.

Test Plan:
- Cold read miss:
  - Stimulus: after reset, mem_read @0x0000_0044; pmem returns a line with word1=0xDEAD_BEEF after 3 cycles.
  - Required: pmem_read with pmem_address=0x0000_0040; no pmem_write; one cycle after pmem_resp, mem_resp=1 with mem_rdata=0xDEAD_BEEF.
- Read hit / back-to-back:
  - Stimulus: consecutive mem_read @0x44 then @0x40 after the fill.
  - Required: mem_resp=1 in the same cycle for each, no pmem activity, correct words returned.
- Byte-enable write hit:
  - Stimulus: word @0x44 = 0xDEAD_BEEF; write 0x1122_3344 with mem_byte_enable=4'b0101.
  - Required: a following read returns 0xDE22_BE44; dirty bit set.
- Dirty eviction:
  - Stimulus: set 2 holds a dirty line; read 0x0000_0140, which maps to set 2 with a different tag.
  - Required: pmem_write first at 0x0000_0040 with the modified line as pmem_wdata; pmem_read at 0x0000_0140 only after that pmem_resp; then mem_resp.
- Read+write simultaneous:
  - Stimulus: mem_read=mem_write=1 on a hit, byte_enable=4'hF, wdata=0xA5A5_A5A5.
  - Required: handled as a write; dirty set; a later read returns 0xA5A5_A5A5.
- Reset mid-fill:
  - Stimulus: assert rst while in ALLOCATE with pmem_read=1.
  - Required: pmem_read=0 and mem_resp=0 without waiting for a clock edge; after release, a re-read of the same address misses again.
